tag_lookup_ctrl: RTL and testbench

- Controller that sits directly upstream of the synchronous-read tag RAM (registered read address, 1-cycle read latency, write-enable port).
- Accepts lookup requests, drives the RAM address, write enable and write data, and consumes its read data.
- Compares the stored tag and valid bit against the request and returns hit or miss. Optionally allocates on a miss.
- Provides a flush that invalidates every entry.

---
 rtl/tag_lookup_ctrl.sv | 97 +++++++++
 tb/tb_tag_lookup_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl: hit/miss lookup, optional miss allocate and full flush over a 1-cycle-latency tag RAM
module tag_lookup_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 6,
  localparam int DWIDTH = TWIDTH + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TWIDTH+AWIDTH-1:0] req_addr,
  input  logic                     req_alloc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_hit,
  output logic [AWIDTH-1:0]        rsp_index,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [DWIDTH-1:0]        ram_din,
  output logic                     ram_we,
  input  logic [DWIDTH-1:0]        ram_dout
);
  localparam int DEPTH = 1 << AWIDTH;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, FLUSH} state_t;
  state_t              state;
  logic [TWIDTH-1:0]   tag;
  logic [AWIDTH-1:0]   idx;
  logic [AWIDTH-1:0]   cnt;
  logic                alloc;
  logic                pend;
  logic                hit;
  assign hit       = ram_dout[DWIDTH-1] && (ram_dout[TWIDTH-1:0] == tag);
  assign req_ready = (state == IDLE) && !pend && !flush_req;
  // IDLE presents the incoming index so the RAM data is ready in LOOKUP
  always_comb begin
    ram_addr = state == IDLE ? req_addr[AWIDTH-1:0] : state == FLUSH ? cnt : idx;
    ram_we   = !reset && (state == FLUSH || (state == LOOKUP && !hit && alloc));
    ram_din  = (state == LOOKUP && ram_we) ? {1'b1, tag} : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tag        <= '0;
      idx        <= '0;
      alloc      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_index  <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      pend       <= 1'b0;
      cnt        <= '0;
    end else begin
      flush_done <= 1'b0;
      if (flush_req && state != IDLE && state != FLUSH) pend <= 1'b1;
      case (state)
        IDLE: begin
          if (pend || flush_req) begin
            state      <= FLUSH;
            pend       <= 1'b0;
            flush_busy <= 1'b1;
          end else if (req_valid) begin
            tag   <= req_addr[TWIDTH+AWIDTH-1:AWIDTH];
            idx   <= req_addr[AWIDTH-1:0];
            alloc <= req_alloc;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          rsp_hit   <= hit;
          rsp_index <= idx;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        FLUSH: begin
          if (cnt == AWIDTH'(DEPTH - 1)) begin
            cnt        <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb_tag_lookup_ctrl: scoreboard bench with a behavioural sync-read tag RAM
module tb_tag_lookup_ctrl;
  localparam int AW = 3;
  localparam int TW = 6;
  localparam int DW = TW + 1;
  logic clock = 0;
  logic reset = 1;
  logic req_valid = 0;
  logic req_ready;
  logic [TW+AW-1:0] req_addr = '0;
  logic req_alloc = 0;
  logic rsp_valid;
  logic rsp_ready = 0;
  logic rsp_hit;
  logic [AW-1:0] rsp_index;
  logic flush_req = 0;
  logic flush_busy;
  logic flush_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic ram_we;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] mem [8];
  logic [DW-1:0] ref_mem [8];
  typedef struct packed {logic hit; logic [AW-1:0] idx;} exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  always #5 clock = ~clock;
  tag_lookup_ctrl dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_alloc(req_alloc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_index(rsp_index), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end
  task chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask
  task send(input logic [TW+AW-1:0] a, input logic al);
    exp_t e;
    logic [DW-1:0] w;
    logic wr;
    req_addr  = a;
    req_alloc = al;
    req_valid = 1;
    w     = ref_mem[a[AW-1:0]];
    e.hit = w[DW-1] && (w[TW-1:0] == a[TW+AW-1:AW]);
    e.idx = a[AW-1:0];
    wr    = !e.hit && al;
    if (wr) ref_mem[a[AW-1:0]] = {1'b1, a[TW+AW-1:AW]};
    q.push_back(e);
    chk("req_ready", req_ready, 1);
    @(posedge clock);
    #1 req_valid = 0;
    chk("lk_we", ram_we, wr);
    chk("lk_addr", ram_addr, a[AW-1:0]);
    chk("lk_din", ram_din, wr ? {1'b1, a[TW+AW-1:AW]} : 7'd0);
  endtask
  task rsp(input int hold, input logic inj);
    int n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clock);
      #1 n++;
    end
    chk("lat", n, 1);
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
      e = '0;
    end else e = q.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_hit", rsp_hit, e.hit);
      chk("hold_idx", rsp_index, e.idx);
      chk("hold_ready", req_ready, 0);
      chk("hold_we", ram_we, 0);
      if (inj && i == 0) begin
        flush_req = 1;
        req_valid = 1;
        req_addr  = 9'b101100_010;
        req_alloc = 0;
      end
      @(posedge clock);
      #1 flush_req = 0;
    end
    chk("rsp_hit", rsp_hit, e.hit);
    chk("rsp_idx", rsp_index, e.idx);
    rsp_ready = 1;
    @(posedge clock);
    #1 rsp_ready = 0;
    chk("rsp_clr", rsp_valid, 0);
  endtask
  task walk;
    for (int i = 0; i < 8; i++) begin
      chk("fl_busy", flush_busy, 1);
      chk("fl_we", ram_we, 1);
      chk("fl_addr", ram_addr, i);
      chk("fl_din", ram_din, 0);
      chk("fl_done_early", flush_done, 0);
      @(posedge clock);
      #1;
    end
    chk("fl_busy_end", flush_busy, 0);
    chk("fl_done", flush_done, 1);
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [TW+AW-1:0] ra;
    @(posedge clock);
    #1 chk("rst_we", ram_we, 0);
    @(posedge clock);
    #1 reset = 0;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_done", flush_done, 0);
    flush_req = 1;
    @(posedge clock);
    #1 flush_req = 0;
    walk();
    @(posedge clock);
    #1 chk("fl_done_pulse", flush_done, 0);
    send(9'b101011_010, 0); rsp(0, 0);
    send(9'b101011_010, 1); rsp(0, 0);
    send(9'b101011_010, 0); rsp(0, 0);
    send(9'b101100_010, 1); rsp(0, 0);
    send(9'b101011_010, 0); rsp(5, 0);
    send(9'b101100_010, 0); rsp(2, 1);
    chk("pend_ready", req_ready, 0);
    @(posedge clock);
    #1 walk();
    send(9'b101100_010, 0); rsp(0, 0);
    req_addr  = 9'b000001_101;
    req_alloc = 1;
    req_valid = 1;
    @(posedge clock);
    #1 req_valid = 0;
    reset = 1;
    #1 chk("rst_lk_we", ram_we, 0);
    @(posedge clock);
    #1 reset = 0;
    chk("rst_lk_valid", rsp_valid, 0);
    chk("rst_lk_ready", req_ready, 1);
    send(9'b000001_101, 0); rsp(0, 0);
    for (int k = 0; k < 12; k++) begin
      ra = TW'($urandom_range(0, 3)) << AW | AW'($urandom_range(0, 7));
      send(ra, 1'($urandom_range(0, 1)));
      rsp($urandom_range(0, 2), 0);
    end
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
